// File: rtl/mem_pattern_tester_if.sv
// Word-addressed request/ack memory bus shared by the pattern tester (master)
// and the memory controller under test (slave).
interface mem_pattern_tester_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_pattern_tester.sv
// Memory self-test engine: write-then-readback pattern pass or read-only
// checksum pass over an inclusive word range, with timeout and abort.
module mem_pattern_tester #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               mode_i,
  input  logic [DATA_WIDTH-1:0]    seed_i,
  input  logic [ADDR_WIDTH-1:0]    start_addr_i,
  input  logic [ADDR_WIDTH-1:0]    end_addr_i,
  mem_pattern_tester_if.master     mem,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               status_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o,
  output logic [DATA_WIDTH-1:0]    first_err_data_o,
  output logic [DATA_WIDTH-1:0]    checksum_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_ADDR     = 2'd0,
    MODE_WALK     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_CHECKSUM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_PASS     = 2'd0,
    ST_MISMATCH = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_ABORT    = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP_W,
    S_READ,
    S_GAP_R,
    S_DONE
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input mode_e                 m,
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] base;
    case (m)
      MODE_ADDR: base = DATA_WIDTH'(a);
      MODE_WALK: base = DATA_WIDTH'(1) << (a % ADDR_WIDTH'(DATA_WIDTH));
      default:   base = a[0] ? '1 : '0;
    endcase
    return base ^ s;
  endfunction

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_WIDTH-1:0]   end_addr_q, end_addr_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    last_q, last_d;
  status_e                 status_q, status_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
  logic [DATA_WIDTH-1:0]   first_err_data_q, first_err_data_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;

  logic                    req_active;
  logic                    tmo_expired;
  logic                    at_end;
  logic [DATA_WIDTH-1:0]   pat_data;

  assign req_active  = (state_q == S_WRITE) || (state_q == S_READ);
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign at_end      = (cur_addr_q == end_addr_q);
  assign pat_data    = pattern(mode_q, cur_addr_q, seed_q);

  // NOTE: every variable written here gets its hold value first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    seed_d           = seed_q;
    start_addr_d     = start_addr_q;
    end_addr_d       = end_addr_q;
    cur_addr_d       = cur_addr_q;
    last_d           = last_q;
    status_d         = status_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    checksum_d       = checksum_q;
    // The wait counter restarts whenever mem_req is low, i.e. on every rise.
    tmo_d            = req_active ? tmo_q + TW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d           = mode_e'(mode_i);
          seed_d           = seed_i;
          start_addr_d     = start_addr_i;
          end_addr_d       = end_addr_i;
          cur_addr_d       = start_addr_i;
          last_d           = 1'b0;
          status_d         = ST_PASS;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_data_d = '0;
          checksum_d       = '0;
          if (end_addr_i < start_addr_i) begin
            status_d = ST_ABORT;
            state_d  = S_DONE;
          end else if (mode_e'(mode_i) == MODE_CHECKSUM) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (mem.mem_ack) begin
          if (at_end) begin
            cur_addr_d = start_addr_q;
            state_d    = S_GAP_R;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
            state_d    = S_GAP_W;
          end
        end else if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      S_GAP_W: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_READ: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (mem.mem_ack) begin
          checksum_d = checksum_q + mem.mem_rdata;
          if (mode_q != MODE_CHECKSUM && mem.mem_rdata != pat_data) begin
            if (err_count_q == '0) begin
              first_err_addr_d = cur_addr_q;
              first_err_data_d = mem.mem_rdata;
            end
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            end
          end
          // The last read still pays its gap cycle before DONE.
          if (at_end) begin
            last_d = 1'b1;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          end
          state_d = S_GAP_R;
        end else if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      S_GAP_R: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (last_q) begin
          status_d = (err_count_q != '0) ? ST_MISMATCH : ST_PASS;
          state_d  = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      mode_q           <= MODE_ADDR;
      seed_q           <= '0;
      start_addr_q     <= '0;
      end_addr_q       <= '0;
      cur_addr_q       <= '0;
      tmo_q            <= '0;
      last_q           <= 1'b0;
      status_q         <= ST_PASS;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      checksum_q       <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      seed_q           <= seed_d;
      start_addr_q     <= start_addr_d;
      end_addr_q       <= end_addr_d;
      cur_addr_q       <= cur_addr_d;
      tmo_q            <= tmo_d;
      last_q           <= last_d;
      status_q         <= status_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      checksum_q       <= checksum_d;
    end
  end

  // Bus outputs decode from state so reset or abort drops mem_req at once.
  assign mem.mem_req   = req_active;
  assign mem.mem_we    = (state_q == S_WRITE);
  assign mem.mem_addr  = req_active ? cur_addr_q : '0;
  assign mem.mem_wdata = (state_q == S_WRITE) ? pat_data : '0;

  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign status_o         = status_q;
  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;
  assign first_err_data_o = first_err_data_q;
  assign checksum_o       = checksum_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Scoreboard bench for mem_pattern_tester: a behavioural memory model answers
// the bus while a monitor checks writes and results against queued expectations.
module tb_mem_pattern_tester;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int EW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] seed_i;
  logic [AW-1:0] start_addr_i;
  logic [AW-1:0] end_addr_i;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    status_o;
  logic [EW-1:0] err_count_o;
  logic [AW-1:0] first_err_addr_o;
  logic [DW-1:0] first_err_data_o;
  logic [DW-1:0] checksum_o;

  mem_pattern_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_pattern_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .seed_i(seed_i), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .mem(bus.master), .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
    .first_err_data_o(first_err_data_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ack after `lat` wait cycles, reads optionally corrupted.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] corrupt [256];
  int            lat = 0;
  bit            never_ack = 1'b0;
  int            wait_cnt = 0;

  assign bus.mem_ack   = bus.mem_req && !never_ack && (wait_cnt >= lat);
  assign bus.mem_rdata = mem[bus.mem_addr] ^ corrupt[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
    if (bus.mem_req && bus.mem_we && bus.mem_ack) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {
    logic [1:0]    status;
    logic [EW-1:0] errs;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fdata;
    logic [DW-1:0] sum;
    int            done_cyc;
    bit            chk_cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int m, input logic [AW-1:0] a, input logic [DW-1:0] s);
    case (m)
      0:       return DW'(a) ^ s;
      1:       return (DW'(1) << (a % DW)) ^ s;
      default: return (a % 2 == 1) ? ~s : s;
    endcase
  endfunction

  // Monitor: consumes expected writes and end-of-test results as they appear.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (!rst) begin
      if (bus.mem_req) req_total++;
      if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
        check("write_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, w.addr);
          check("wr_data", bus.mem_wdata, w.data);
        end
      end
      if (done_o) begin
        check("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("busy_at_done", busy_o, 0);
          check("status", status_o, e.status);
          check("err_count", err_count_o, e.errs);
          check("first_err_addr", first_err_addr_o, e.faddr);
          check("first_err_data", first_err_data_o, e.fdata);
          check("checksum", checksum_o, e.sum);
          if (e.chk_cyc) check("done_cycle", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic check_all_zero();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_status", status_o, 0);
    check("rst_err_count", err_count_o, 0);
    check("rst_first_err_addr", first_err_addr_o, 0);
    check("rst_first_err_data", first_err_data_o, 0);
    check("rst_checksum", checksum_o, 0);
  endtask

  // Runs one test; abort_rd>0 aborts during that read, never=1 withholds acks.
  task automatic run_test(input int mode, input logic [DW-1:0] seed,
                          input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input int l, input bit never, input int abort_rd,
                          input bit abort_with_start, input bit restart_busy);
    exp_t          e;
    int            w, nrd, errs, off, n, req0, rd_seen;
    bit            prev, got_done;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    lat = l;
    never_ack = never;
    e.status = 0; e.errs = 0; e.faddr = 0; e.fdata = 0; e.sum = 0;
    e.chk_cyc = (abort_rd == 0);
    errs = 0;
    w = (ea < sa) ? 0 : int'(ea) - int'(sa) + 1;
    nrd = never ? 0 : (abort_rd != 0) ? abort_rd - 1 : w;
    for (int i = 0; i < w; i++) begin
      a = sa + AW'(i);
      if (mode != 3) begin
        d = pat(mode, a, seed);
        if (!never) wr_q.push_back('{a, d});
      end else begin
        d = mem[a];
      end
      if (i < nrd) begin
        rd = d ^ corrupt[a];
        e.sum += rd;
        if (mode != 3 && corrupt[a] != 0) begin
          if (errs == 0) begin
            e.faddr = a;
            e.fdata = rd;
          end
          errs++;
        end
      end
    end
    e.errs = (errs > (1 << EW) - 1) ? EW'((1 << EW) - 1) : EW'(errs);
    if (w == 0 || abort_rd != 0) e.status = 2'd3;
    else if (never)              e.status = 2'd2;
    else                         e.status = (errs != 0) ? 2'd1 : 2'd0;
    off = never ? TMO : ((mode == 3) ? w : 2 * w) * (l + 2);

    @(negedge clk);
    start_i = 1'b1; abort_i = abort_with_start; mode_i = 2'(mode);
    seed_i = seed; start_addr_i = sa; end_addr_i = ea;
    req0 = req_total;
    @(posedge clk);
    #1;
    n = cyc;
    e.done_cyc = n + off;
    exp_q.push_back(e);
    if (w > 0) begin
      check("busy_after_start", busy_o, 1);
      check("req_after_start", bus.mem_req, 1);
    end
    abort_i = 1'b0;
    if (restart_busy) begin
      mode_i = ~mode_i; seed_i = ~seed; start_addr_i = ea + 1'b1; end_addr_i = ea;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;

    rd_seen = 0; prev = 1'b0; got_done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      if (abort_rd != 0) begin
        if (bus.mem_req && !bus.mem_we && !prev) rd_seen++;
        prev = bus.mem_req && !bus.mem_we;
        if (rd_seen == abort_rd) begin
          abort_i = 1'b1;
          @(posedge clk);
          #1 abort_i = 1'b0;
          @(negedge clk);
          check("req_after_abort", bus.mem_req, 0);
          got_done = done_o;
          break;
        end
      end
    end
    check("done_seen", got_done, 1);
    @(posedge clk);
    #1;
    check("writes_consumed", wr_q.size(), 0);
    check("results_consumed", exp_q.size(), 0);
    if (never) check("req_high_cycles", req_total - req0, TMO);
    if (w == 0) check("bad_range_no_req", req_total - req0, 0);
    wr_q.delete();
    exp_q.delete();
    never_ack = 1'b0;
  endtask

  initial begin
    int            len;
    logic [AW-1:0] sa;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      corrupt[i] = '0;
    end
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = '0; seed_i = '0;
    start_addr_i = '0; end_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero();
    rst = 1'b0;

    // Address pattern, clean then with bit 0 flipped at 0x12.
    run_test(0, '0, 8'h10, 8'h13, 0, 0, 0, 0, 0);
    corrupt[8'h12] = 32'h1;
    run_test(0, '0, 8'h10, 8'h13, 0, 0, 0, 0, 0);
    corrupt[8'h12] = '0;

    // Read-only checksum over preloaded words.
    mem[8'h40] = 32'h1; mem[8'h41] = 32'h2; mem[8'h42] = 32'h3; mem[8'h43] = 32'hFFFF_FFFF;
    run_test(3, $urandom, 8'h40, 8'h43, 0, 0, 0, 0, 0);

    // Timeout, bad range, abort in third read, start+abort together.
    run_test(0, $urandom, 8'h50, 8'h53, 0, 1, 0, 0, 0);
    run_test(0, $urandom, 8'h05, 8'h04, 0, 0, 0, 0, 0);
    run_test(2, $urandom, 8'h20, 8'h23, 3, 0, 3, 0, 0);
    run_test(2, $urandom, 8'h60, 8'h62, 0, 0, 0, 1, 0);

    // Range ending at all-ones, single word, saturating error count.
    run_test(1, $urandom, 8'hFC, 8'hFF, 1, 0, 0, 0, 0);
    run_test(2, $urandom, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    for (int i = 8'h80; i <= 8'h89; i++) corrupt[i] = $urandom | 32'h1;
    run_test(0, $urandom, 8'h80, 8'h89, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) corrupt[i] = '0;

    // Reset while the first write is waiting for its ack.
    lat = 3;
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'd1; seed_i = $urandom; start_addr_i = 8'h30; end_addr_i = 8'h37;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    check("write_before_reset", bus.mem_req && bus.mem_we, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero();
    rst = 1'b0;

    // Randomised passes over small ranges with random wait states and faults.
    for (int t = 0; t < 16; t++) begin
      len = $urandom_range(1, 8);
      sa  = AW'($urandom_range(0, 247));
      for (int j = 0; j < len; j++)
        if ($urandom_range(0, 3) == 0) corrupt[sa + AW'(j)] = $urandom | 32'h1;
      run_test($urandom_range(0, 3), $urandom, sa, sa + AW'(len - 1),
               $urandom_range(0, 2), 0, 0, 0, 1'($urandom_range(0, 1)));
      for (int j = 0; j < len; j++) corrupt[sa + AW'(j)] = '0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
